// File: rtl/sub128_pkg.sv
// rtl/sub128_pkg.sv - shared state encoding and default sizing for sub128_seq
package sub128_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_CHUNK  = 16;
  localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational CHUNK-bit subtract-with-borrow slice
//  a, b   in   CHUNK  slice operands
//  bin    in   1      borrow into the slice
//  d      out  CHUNK  slice difference
//  bout   out  1      borrow out of the slice
module sub_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] sum;

  // Two's-complement subtract: a + ~b + carry, carry-in is the inverted borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
    d    = sum[CHUNK-1:0];
    bout = ~sum[CHUNK];
  end

endmodule

// File: rtl/sub128_seq.sv
// rtl/sub128_seq.sv - multi-cycle WIDTH-bit subtractor, one CHUNK slice per clock
//  clk, rst          clock, asynchronous active-high reset
//  in_valid/in_ready operand handshake (a, b, bin)
//  out_valid/out_ready result handshake (d, bout)
//  zero, ovf         result flags, present only when SUB128_FLAGS_EN is defined
module sub128_seq
  import sub128_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
`ifdef SUB128_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("sub128_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] d_s;
  logic             bo_s;
  logic             last;

  always_comb begin
    a_s  = a_r[int'(idx)*CHUNK +: CHUNK];
    b_s  = b_r[int'(idx)*CHUNK +: CHUNK];
    last = (idx == IDX_W'(NCHUNK - 1));
  end

  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (borrow),
    .d    (d_s),
    .bout (bo_s)
  );

`ifdef SUB128_FLAGS_EN
  // Full result as it will look once the current slice is written; flags
  // are taken from this on the final slice so they line up with out_valid.
  logic [WIDTH-1:0] d_full;
  always_comb begin
    d_full = d;
    d_full[int'(idx)*CHUNK +: CHUNK] = d_s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      d         <= '0;
      bout      <= 1'b0;
`ifdef SUB128_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow   <= bin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          d[int'(idx)*CHUNK +: CHUNK] <= d_s;
          borrow <= bo_s;
          if (last) begin
            bout      <= bo_s;
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef SUB128_FLAGS_EN
            zero <= (d_full == '0);
            ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_full[WIDTH-1] != a_r[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          // New operands are never taken here; in_ready rises only back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub128_seq.sv
// tb/tb_sub128_seq.sv - directed self-checking bench for sub128_seq
module tb_sub128_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] a = '0;
  logic [127:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] d;
  logic         bout;
`ifdef SUB128_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] ONES = {128{1'b1}};

  sub128_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
`ifdef SUB128_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present operands in IDLE, then wait for out_valid and check the result.
  task automatic run_op(input string tag, input logic [127:0] va, input logic [127:0] vb,
                        input logic vbin, input logic [127:0] ed, input logic eb);
    int lat;
    check({tag, ".in_ready"}, {127'd0, in_ready}, 128'd1);
    a = va;
    b = vb;
    bin = vbin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 128'(lat), 128'd8);
    check({tag, ".d"}, d, ed);
    check({tag, ".bout"}, {127'd0, bout}, {127'd0, eb});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    // 1: reset held three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", {127'd0, out_valid}, 128'd0);
    check("rst.d", d, 128'd0);
    check("rst.bout", {127'd0, bout}, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.in_ready", {127'd0, in_ready}, 128'd1);

    // 2: basic subtract
    run_op("basic", 128'd100, 128'd25, 1'b0, 128'd75, 1'b0);
    release_result("basic");

    // 3: wrap-around
    run_op("wrap", 128'd0, 128'd1, 1'b0, ONES, 1'b1);
    release_result("wrap");

    // 4: borrow across slice 0/1, and borrow-in on equal operands
    run_op("xslice", 128'h1_0000, 128'd1, 1'b0, 128'hFFFF, 1'b0);
    release_result("xslice");
    run_op("bin", 128'd5, 128'd5, 1'b1, ONES, 1'b1);
    release_result("bin");

    // 5: backpressure in DONE with a competing new operand
    run_op("bp", 128'd1000, 128'd1, 1'b0, 128'd999, 1'b0);
    a = 128'd50;
    b = 128'd8;
    bin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold_d", d, 128'd999);
      check("bp.hold_bout", {127'd0, bout}, 128'd0);
      check("bp.hold_valid", {127'd0, out_valid}, 128'd1);
      check("bp.hold_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp.idle_in_ready", {127'd0, in_ready}, 128'd1);
    run_op("bp_next", 128'd50, 128'd8, 1'b0, 128'd42, 1'b0);
    release_result("bp_next");

    // 6: reset pulsed part way through RUN
    a = 128'd1000;
    b = 128'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst.out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst.d", d, 128'd0);
    check("mid_rst.bout", {127'd0, bout}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst.no_result", {127'd0, out_valid}, 128'd0);
    end
    run_op("after_rst", 128'd7, 128'd3, 1'b0, 128'd4, 1'b0);
    release_result("after_rst");

`ifdef SUB128_FLAGS_EN
    run_op("flag_zero", 128'd9, 128'd9, 1'b0, 128'd0, 1'b0);
    check("flag_zero.zero", {127'd0, zero}, 128'd1);
    check("flag_zero.ovf", {127'd0, ovf}, 128'd0);
    release_result("flag_zero");
    run_op("flag_ovf", {1'b1, 127'd0}, 128'd1, 1'b0, {1'b0, {127{1'b1}}}, 1'b0);
    check("flag_ovf.ovf", {127'd0, ovf}, 128'd1);
    check("flag_ovf.zero", {127'd0, zero}, 128'd0);
    release_result("flag_ovf");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
